hmmm_pad_bridge: RTL and testbench
==================================

# hmmm_pad_bridge

Parametrised pad-side controller between the caravel user area and the Hmmm core. It provides a synchronised serial program loader that writes program memory and a run/halt sequencer that owns the core's reset. It also registers the core's bidirectional data bus onto GPIO pads with correct `oeb` control. It sits in `user_project_wrapper` between the pads and `hmmm`, generalising data and address widths and adding framing, error reporting and halt/restart behaviour.

## Interface
Parameters:
- `DATA_W`, default 16: core bus and program word width.
- `ADDR_W`, default 8: program memory address width.
- `SYNC_STAGES`, default 2: flop depth of every pad-input synchroniser; must be at least 2.

Ports:
- `clk`  in  1  single clock, `wb_clk_i` at wrapper level.
- `rst`  in  1  asynchronous, active-high reset.
- `pad_sen`  in  1  serial-load enable (asynchronous pad).
- `pad_sclk`  in  1  serial bit clock (asynchronous pad, sampled).
- `pad_sdi`  in  1  serial data, MSB first.
- `pad_go`  in  1  run request (asynchronous pad, rising edge).
- `mem_we`  out  1  program-memory write strobe, one cycle.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  DATA_W  write data.
- `core_rst`  out  1  reset to core.
- `core_halt`  in  1  core halt indication.
- `core_write`  in  1  core drives bus.
- `core_bus_o`  in  DATA_W  core write data.
- `core_bus_i`  out  DATA_W  synchronised pad data to core.
- `pad_bus_o`  out  DATA_W  pad output data.
- `pad_bus_i`  in  DATA_W  pad input data.
- `pad_bus_oeb`  out  DATA_W  pad output-enable-bar: 1 means input.
- `pad_halt`  out  1  halted status to pad.
- `frame_err`  out  1  sticky aborted-frame flag.
- `state_o`  out  2  current FSM state.

## Operation
- **Synchronisers.** `pad_sen`, `pad_sclk`, `pad_sdi`, `pad_go` and `pad_bus_i` each pass through `SYNC_STAGES` flops.
  - `sclk` and `go` rising edges are detected on the synchronised value (one extra flop).
  - `sdi` carries one extra flop so it stays aligned with the `sclk` edge.
- **FSM states and encoding.** IDLE=0 (reset state), LOAD=1, RUN=2, HALTED=3.
- **State transitions.**
  - IDLE: synchronised `sen`=1 goes to LOAD; else a `go` rise goes to RUN.
  - LOAD: `sen`=0 goes to IDLE.
  - RUN: `core_halt`=1 goes to HALTED. `sen` and `go` are ignored.
  - HALTED: `sen`=1 goes to LOAD; else a `go` rise goes to RUN. If both occur in the same cycle, LOAD wins.
- **Core reset.** `core_rst` = (state != RUN), registered from next-state. `core_halt` is ignored outside RUN.
- **Loader framing.**
  - A frame is `ADDR_W+DATA_W` bits: address first, then data, each MSB first.
  - The bit counter has width clog2(`ADDR_W+DATA_W`) and is cleared on LOAD entry.
  - On each `sclk` rise in LOAD, the shift register takes `sdi` and the counter increments.
  - On the final bit, the counter wraps to 0. On the next cycle `mem_we`=1 for exactly one cycle, with `mem_addr`/`mem_wdata` holding the frame contents.
  - `mem_addr`/`mem_wdata` hold their values until the next frame completes.
  - Back-to-back frames need no gap.
- **Aborted frame.** Leaving LOAD with a nonzero bit counter discards the partial frame, produces no `mem_we`, and sets `frame_err`. `frame_err` clears on the next LOAD entry.
- **Bus.**
  - `pad_bus_o` is registered `core_bus_o`.
  - `pad_bus_oeb` is registered: all 0 when (state==RUN && `core_write`), else all 1.
  - `core_bus_i` is the synchronised `pad_bus_i`.
- **Halt status.** `pad_halt` = (state==HALTED), registered.

## Timing
- **Reset values.**
  - state IDLE, `core_rst` 1, `mem_we` 0.
  - `mem_addr`, `mem_wdata`, `pad_bus_o`, `core_bus_i` all 0.
  - `pad_bus_oeb` all 1, `pad_halt` 0, `frame_err` 0.
- **Reset mid-operation.** Asserting `rst` mid-frame or mid-run returns everything to the reset values immediately (asynchronous). No `mem_we` is emitted.
- **Pad edge to action.** A pad edge acts `SYNC_STAGES+1` cycles later. Examples: `go` rise to `core_rst` low; final `sclk` rise to `mem_we`.
- **Serial clock rate.** `pad_sclk` high and low phases must each last at least `SYNC_STAGES+1` clk cycles. Faster serial clocks are out of spec.
- **Bus latency.** `core_write` to `pad_bus_oeb` change: 1 cycle. `pad_bus_i` to `core_bus_i`: `SYNC_STAGES` cycles.
- **Halt latency.** `core_halt` to `pad_halt`: 1 cycle, with `core_rst` asserting on the same edge.

## Structure
- **Package `hmmm_bridge_pkg`.**
  - `bridge_state_t` enum (IDLE/LOAD/RUN/HALTED, 2 bits).
  - `FRAME_W` helper function returning `ADDR_W+DATA_W`.
  - `OEB_INPUT`/`OEB_DRIVE` constants.
- **Sub-module `hmmm_sync`.** Parametrised width × `SYNC_STAGES` synchroniser with async reset to 0. Instantiated once for the control pads (plus the alignment flop) and once for `pad_bus_i`.

## Test plan
- **Single frame.** `ADDR_W`=8, `DATA_W`=16; shift 0x05 then 0x1234 in LOAD → exactly one `mem_we` pulse with `mem_addr`=0x05, `mem_wdata`=0x1234, `frame_err`=0.
- **Aborted frame.** Drop `sen` after 10 bits → no `mem_we`, `frame_err`=1, state IDLE. Re-enter LOAD → `frame_err`=0.
- **Run and halt.** `go` rise in IDLE → `core_rst` 1→0 after `SYNC_STAGES+1` cycles. Raise `core_halt` → `pad_halt`=1 and `core_rst`=1 next cycle. A second `go` → RUN again.
- **Bus write and read.**
  - In RUN, `core_write`=1 with `core_bus_o`=0xBEEF → next cycle `pad_bus_oeb`=0x0000, `pad_bus_o`=0xBEEF.
  - `core_write`=0 → `oeb`=0xFFFF.
  - `pad_bus_i`=0x00A5 → `core_bus_i`=0x00A5 after 2 cycles.
- **Priority and ignored inputs.** In HALTED with `sen` and `go` rising in the same cycle → LOAD. In RUN, `sen`=1 → state stays RUN.
- **Reset mid-frame.** Assert `rst` mid-frame → all outputs at reset values, no `mem_we`. A subsequent full frame loads correctly.

Source files
------------

// File: rtl/hmmm_bridge_pkg.sv
// Shared types and constants for the Hmmm pad bridge: FSM encoding, frame
// width helper and pad output-enable polarity.
package hmmm_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } bridge_state_t;

  // Caravel pads use output-enable-bar: high means the pad is an input.
  localparam logic OEB_INPUT = 1'b1;
  localparam logic OEB_DRIVE = 1'b0;

  function automatic int FRAME_W(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/hmmm_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous pad inputs; each bit is
// synchronised independently, so only use it for slow or quasi-static signals.
module hmmm_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  // NOTE: every stage is reset so the synchronised outputs are defined from the first cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= '0;
    else     stage_q <= {stage_q[STAGES-2:0], d};
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/hmmm_pad_bridge.sv
// Pad-side controller for the Hmmm core: serial program loader, run/halt
// sequencer owning the core reset, and registered GPIO data bus with oeb.
module hmmm_pad_bridge
  import hmmm_bridge_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pad_sen,
  input  logic              pad_sclk,
  input  logic              pad_sdi,
  input  logic              pad_go,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_rst,
  input  logic              core_halt,
  input  logic              core_write,
  input  logic [DATA_W-1:0] core_bus_o,
  output logic [DATA_W-1:0] core_bus_i,
  output logic [DATA_W-1:0] pad_bus_o,
  input  logic [DATA_W-1:0] pad_bus_i,
  output logic [DATA_W-1:0] pad_bus_oeb,
  output logic              pad_halt,
  output logic              frame_err,
  output logic [1:0]        state_o
);

  localparam int FW    = FRAME_W(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(FW);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FW - 1);

  bridge_state_t   state, state_nx;
  logic [3:0]      ctrl_s;
  logic            sen_s, sclk_s, sdi_s, go_s;
  logic            sclk_d, go_d, sdi_d;
  logic            sclk_rise, go_rise;
  logic [CNT_W-1:0] bit_cnt;
  logic [FW-1:0]   shift_q;
  logic [FW-1:0]   frame_full;
  logic            entering, leaving, in_load;

  hmmm_sync #(.WIDTH(4), .STAGES(SYNC_STAGES)) u_ctrl_sync (
    .clk (clk),
    .rst (rst),
    .d   ({pad_sen, pad_sclk, pad_sdi, pad_go}),
    .q   (ctrl_s)
  );

  hmmm_sync #(.WIDTH(DATA_W), .STAGES(SYNC_STAGES)) u_bus_sync (
    .clk (clk),
    .rst (rst),
    .d   (pad_bus_i),
    .q   (core_bus_i)
  );

  assign {sen_s, sclk_s, sdi_s, go_s} = ctrl_s;

  // sdi is delayed alongside sclk so the sampled bit matches the detected edge.
  // NOTE: sequential state is written with non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_d <= 1'b0;
      go_d   <= 1'b0;
      sdi_d  <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      go_d   <= go_s;
      sdi_d  <= sdi_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign go_rise   = go_s & ~go_d;

  // NOTE: state_nx is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, HALTED: begin
        if (sen_s)        state_nx = LOAD;
        else if (go_rise) state_nx = RUN;
      end
      LOAD: if (!sen_s)     state_nx = IDLE;
      RUN:  if (core_halt)  state_nx = HALTED;
    endcase
  end

  // Status outputs come from next-state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      core_rst <= 1'b1;
      pad_halt <= 1'b0;
    end else begin
      state    <= state_nx;
      core_rst <= (state_nx != RUN);
      pad_halt <= (state_nx == HALTED);
    end
  end

  assign entering   = (state != LOAD) && (state_nx == LOAD);
  assign leaving    = (state == LOAD) && (state_nx != LOAD);
  assign in_load    = (state == LOAD) && (state_nx == LOAD);
  assign frame_full = {shift_q[FW-2:0], sdi_d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift_q   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      frame_err <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (entering) begin
        bit_cnt   <= '0;
        frame_err <= 1'b0;
      end else if (leaving) begin
        // A partial frame is dropped; only the error flag records it.
        bit_cnt <= '0;
        if (bit_cnt != '0) frame_err <= 1'b1;
      end else if (in_load && sclk_rise) begin
        shift_q <= frame_full;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt   <= '0;
          mem_we    <= 1'b1;
          mem_addr  <= frame_full[FW-1:DATA_W];
          mem_wdata <= frame_full[DATA_W-1:0];
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pad_bus_o   <= '0;
      pad_bus_oeb <= {DATA_W{OEB_INPUT}};
    end else begin
      pad_bus_o   <= core_bus_o;
      pad_bus_oeb <= {DATA_W{((state == RUN) && core_write) ? OEB_DRIVE : OEB_INPUT}};
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_hmmm_pad_bridge.sv
// Directed self-checking bench for hmmm_pad_bridge (DATA_W=16, ADDR_W=8,
// SYNC_STAGES=2): loader framing, abort, run/halt, bus and mid-frame reset.
module tb_hmmm_pad_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        pad_sen, pad_sclk, pad_sdi, pad_go;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        core_rst;
  logic        core_halt, core_write;
  logic [15:0] core_bus_o, core_bus_i, pad_bus_o, pad_bus_i, pad_bus_oeb;
  logic        pad_halt, frame_err;
  logic [1:0]  state_o;

  int n_assert = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int we_snap;
  logic [7:0]  last_addr = '0;
  logic [15:0] last_data = '0;

  hmmm_pad_bridge #(.DATA_W(16), .ADDR_W(8), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pad_sen     (pad_sen),
    .pad_sclk    (pad_sclk),
    .pad_sdi     (pad_sdi),
    .pad_go      (pad_go),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .core_rst    (core_rst),
    .core_halt   (core_halt),
    .core_write  (core_write),
    .core_bus_o  (core_bus_o),
    .core_bus_i  (core_bus_i),
    .pad_bus_o   (pad_bus_o),
    .pad_bus_i   (pad_bus_i),
    .pad_bus_oeb (pad_bus_oeb),
    .pad_halt    (pad_halt),
    .frame_err   (frame_err),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      we_cnt++;
      last_addr = mem_addr;
      last_data = mem_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Each sclk phase is 4 cycles; on the frame's last bit mem_we must appear
  // exactly 3 cycles after the sclk rise and last one cycle.
  task automatic send_bit(input logic b, input bit last);
    pad_sdi  = b;
    pad_sclk = 1'b0;
    step(4);
    pad_sclk = 1'b1;
    if (last) begin
      step(2);
      check("we_early", mem_we, 0);
      step(1);
      check("we_pulse", mem_we, 1);
      step(1);
      check("we_width", mem_we, 0);
    end else begin
      step(4);
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [15:0] d);
    logic [23:0] f;
    f = {a, d};
    for (int i = 23; i >= 0; i--) send_bit(f[i], i == 0);
    pad_sclk = 1'b0;
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) send_bit(i[0], 1'b0);
    pad_sclk = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pad_sen = 0; pad_sclk = 0; pad_sdi = 0; pad_go = 0;
    core_halt = 0; core_write = 0; core_bus_o = '0; pad_bus_i = '0;

    step(3);
    check("rst_state", state_o, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_bus_o", pad_bus_o, 0);
    check("rst_bus_i", core_bus_i, 0);
    check("rst_oeb", pad_bus_oeb, 16'hFFFF);
    check("rst_halt", pad_halt, 0);
    check("rst_ferr", frame_err, 0);
    rst = 1'b0;
    step(2);

    // Single frame, then a back-to-back second frame
    pad_sen = 1'b1;
    step(4);
    check("load_entry", state_o, 1);
    send_frame(8'h05, 16'h1234);
    step(2);
    check("f1_count", we_cnt, 1);
    check("f1_addr", last_addr, 8'h05);
    check("f1_data", last_data, 16'h1234);
    check("f1_hold_addr", mem_addr, 8'h05);
    check("f1_ferr", frame_err, 0);
    send_frame(8'hA0, 16'hC3C3);
    step(1);
    check("f2_count", we_cnt, 2);
    check("f2_addr", mem_addr, 8'hA0);
    check("f2_data", mem_wdata, 16'hC3C3);

    // Aborted frame after 10 bits
    send_partial(10);
    pad_sen = 1'b0;
    step(4);
    check("abort_state", state_o, 0);
    check("abort_ferr", frame_err, 1);
    check("abort_count", we_cnt, 2);
    check("abort_hold", mem_wdata, 16'hC3C3);
    pad_sen = 1'b1;
    step(4);
    check("reload_state", state_o, 1);
    check("reload_ferr", frame_err, 0);
    pad_sen = 1'b0;
    step(4);
    check("empty_exit_state", state_o, 0);
    check("empty_exit_ferr", frame_err, 0);

    // Run: go rise to core_rst low takes 3 cycles
    pad_go = 1'b1;
    step(2);
    check("go_lat_early", core_rst, 1);
    step(1);
    check("go_lat", core_rst, 0);
    check("run_state", state_o, 2);
    pad_go = 1'b0;

    // Bus
    core_write = 1'b1; core_bus_o = 16'hBEEF;
    step(1);
    check("oeb_drive", pad_bus_oeb, 16'h0000);
    check("bus_out", pad_bus_o, 16'hBEEF);
    core_write = 1'b0;
    step(1);
    check("oeb_input", pad_bus_oeb, 16'hFFFF);
    pad_bus_i = 16'h00A5;
    step(1);
    check("bus_in_early", core_bus_i, 16'h0000);
    step(1);
    check("bus_in", core_bus_i, 16'h00A5);

    // sen and go ignored while running
    pad_sen = 1'b1;
    pad_go  = 1'b1;
    step(5);
    check("run_ignore_state", state_o, 2);
    check("run_ignore_rst", core_rst, 0);
    pad_sen = 1'b0;
    pad_go  = 1'b0;
    step(4);

    // Halt
    core_halt = 1'b1;
    step(1);
    check("halt_pad", pad_halt, 1);
    check("halt_core_rst", core_rst, 1);
    check("halt_state", state_o, 3);
    core_halt = 1'b0;
    core_write = 1'b1;
    step(2);
    check("halt_oeb", pad_bus_oeb, 16'hFFFF);
    check("halt_stays", state_o, 3);
    core_write = 1'b0;

    // Restart from HALTED
    pad_go = 1'b1;
    step(3);
    check("rerun_state", state_o, 2);
    check("rerun_core_rst", core_rst, 0);
    check("rerun_halt", pad_halt, 0);
    pad_go = 1'b0;
    step(3);
    core_halt = 1'b1;
    step(1);
    check("halt2_state", state_o, 3);
    core_halt = 1'b0;

    // sen and go together in HALTED: LOAD wins
    pad_sen = 1'b1;
    pad_go  = 1'b1;
    step(3);
    check("prio_state", state_o, 1);
    check("prio_core_rst", core_rst, 1);
    check("prio_halt", pad_halt, 0);
    pad_sen = 1'b0;
    pad_go  = 1'b0;
    step(4);
    check("prio_exit", state_o, 0);

    // Reset mid-frame
    pad_sen = 1'b1;
    step(4);
    we_snap = we_cnt;
    send_partial(12);
    rst = 1'b1;
    #1;
    check("mrst_state", state_o, 0);
    check("mrst_core_rst", core_rst, 1);
    check("mrst_addr", mem_addr, 0);
    check("mrst_wdata", mem_wdata, 0);
    check("mrst_bus_i", core_bus_i, 0);
    check("mrst_oeb", pad_bus_oeb, 16'hFFFF);
    check("mrst_ferr", frame_err, 0);
    step(2);
    check("mrst_no_we", we_cnt, we_snap);
    rst = 1'b0;
    step(4);
    check("mrst_reload", state_o, 1);
    send_frame(8'h3C, 16'h5AA5);
    step(1);
    check("mrst_count", we_cnt, we_snap + 1);
    check("mrst_f_addr", mem_addr, 8'h3C);
    check("mrst_f_data", mem_wdata, 16'h5AA5);
    check("mrst_f_ferr", frame_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
